// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry and the Gray-to-binary
// helper used by both the read-side and write-side pointer blocks.
package fifo_pkg;

  localparam int FIFO_DATA_W      = 8;
  localparam int FIFO_ADDR_W      = 4;
  localparam int FIFO_AEMPTY_THR  = 2;

  // Zero-extended Gray codes convert correctly, so one 32-bit routine serves every width.
  function automatic logic [31:0] gray2bin_f(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Width-parameterized Gray-to-binary converter (purely combinational).
module gray2bin
  import fifo_pkg::*;
#(
  parameter int width = FIFO_ADDR_W + 1
) (
  input  logic [width-1:0] gray,
  output logic [width-1:0] bin
);

  assign bin = width'(gray2bin_f(32'(gray)));

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer/empty controller of an async FIFO: read pointer in
// binary and Gray, registered empty/almost-empty/level, and 1-cycle read data.
module rptr_empty_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width    = FIFO_DATA_W,
  parameter int add_width     = FIFO_ADDR_W,
  parameter int aempty_thresh = FIFO_AEMPTY_THR
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [add_width:0]    rq2_wptr,
  input  logic [data_width-1:0] rdata_mem,
  output logic [add_width-1:0]  r_addr,
  output logic [add_width:0]    r_ptr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [add_width:0]    rlevel,
  output logic [data_width-1:0] rdata,
  output logic                  rvalid,
  output logic                  runderflow
);

  logic [add_width:0]    rbin_q, rbin_d;
  logic [add_width:0]    rptr_q, rptr_d;
  logic                  rempty_q, rempty_d;
  logic                  raempty_q, raempty_d;
  logic [add_width:0]    rlevel_q, rlevel_d;
  logic [data_width-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  runderflow_q, runderflow_d;

  logic [add_width:0]    wq2_bin;
  logic                  accept;

  gray2bin #(.width(add_width + 1)) u_wq2_g2b (
    .gray (rq2_wptr),
    .bin  (wq2_bin)
  );

  // Empty and level are both computed from the next pointer and the current
  // write pointer, so a read coinciding with a write advance sees both.
  always_comb begin
    accept       = rinc & ~rempty_q;
    rbin_d       = rbin_q + {{add_width{1'b0}}, accept};
    rptr_d       = (rbin_d >> 1) ^ rbin_d;
    rempty_d     = (rptr_d == rq2_wptr);
    rlevel_d     = wq2_bin - rbin_d;
    raempty_d    = (int'(rlevel_d) <= aempty_thresh);
    rdata_d      = accept ? rdata_mem : rdata_q;
    rvalid_d     = accept;
    runderflow_d = runderflow_q | (rinc & rempty_q);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      rdata_q      <= '0;
      rvalid_q     <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rlevel_q     <= rlevel_d;
      rdata_q      <= rdata_d;
      rvalid_q     <= rvalid_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign r_addr     = rbin_q[add_width-1:0];
  assign r_ptr      = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign rdata      = rdata_q;
  assign rvalid     = rvalid_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed bench for rptr_empty_ctrl: a per-cycle vector table plus
// hand-written wrap, full-occupancy and reset-mid-read sequences.
module tb_rptr_empty_ctrl;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       rinc;
  logic [4:0] rq2_wptr;
  logic [7:0] rdata_mem;
  logic [3:0] r_addr;
  logic [4:0] r_ptr;
  logic       rempty, raempty, rvalid, runderflow;
  logic [4:0] rlevel;
  logic [7:0] rdata;

  int checks   = 0;
  int failures = 0;

  always #5 rclk = ~rclk;

  rptr_empty_ctrl #(.data_width(8), .add_width(4), .aempty_thresh(2)) dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rinc       (rinc),
    .rq2_wptr   (rq2_wptr),
    .rdata_mem  (rdata_mem),
    .r_addr     (r_addr),
    .r_ptr      (r_ptr),
    .rempty     (rempty),
    .raempty    (raempty),
    .rlevel     (rlevel),
    .rdata      (rdata),
    .rvalid     (rvalid),
    .runderflow (runderflow)
  );

  typedef struct {
    logic       rinc;
    logic [4:0] wptr;
    logic [7:0] dmem;
    logic       e_empty;
    logic       e_aempty;
    logic [4:0] e_level;
    logic [3:0] e_addr;
    logic [4:0] e_ptr;
    logic       e_valid;
    logic [7:0] e_rdata;
    logic       e_uf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst_n    = 1'b0;
    rinc      = 1'b0;
    rq2_wptr  = '0;
    rdata_mem = '0;
    step();
    step();
    chk("rst_empty",  32'(rempty),     32'd1);
    chk("rst_aempty", 32'(raempty),    32'd1);
    chk("rst_level",  32'(rlevel),     32'd0);
    chk("rst_ptr",    32'(r_ptr),      32'd0);
    chk("rst_valid",  32'(rvalid),     32'd0);
    chk("rst_rdata",  32'(rdata),      32'd0);
    chk("rst_uf",     32'(runderflow), 32'd0);
    rrst_n = 1'b1;
  endtask

  initial begin
    // rinc wptr dmem | empty aempty level addr ptr valid rdata uf
    vecs[0] = '{1'b1, 5'b00000, 8'hAA, 1'b1, 1'b1, 5'd0, 4'd0, 5'b00000, 1'b0, 8'h00, 1'b1}; // underflow
    vecs[1] = '{1'b0, 5'b00010, 8'h00, 1'b0, 1'b0, 5'd3, 4'd0, 5'b00000, 1'b0, 8'h00, 1'b1}; // 3 words
    vecs[2] = '{1'b1, 5'b00010, 8'h11, 1'b0, 1'b1, 5'd2, 4'd1, 5'b00001, 1'b1, 8'h11, 1'b1};
    vecs[3] = '{1'b1, 5'b00010, 8'h22, 1'b0, 1'b1, 5'd1, 4'd2, 5'b00011, 1'b1, 8'h22, 1'b1};
    vecs[4] = '{1'b1, 5'b00010, 8'h33, 1'b1, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b1, 8'h33, 1'b1};
    vecs[5] = '{1'b0, 5'b00010, 8'h44, 1'b1, 1'b1, 5'd0, 4'd3, 5'b00010, 1'b0, 8'h33, 1'b1}; // rdata holds
    vecs[6] = '{1'b0, 5'b00110, 8'h00, 1'b0, 1'b1, 5'd1, 4'd3, 5'b00010, 1'b0, 8'h33, 1'b1}; // level 1
    vecs[7] = '{1'b1, 5'b00111, 8'h55, 1'b0, 1'b1, 5'd1, 4'd4, 5'b00110, 1'b1, 8'h55, 1'b1}; // read + write

    do_reset();
    chk("rst_addr", 32'(r_addr), 32'd0);

    for (int i = 0; i < 8; i++) begin
      rinc      = vecs[i].rinc;
      rq2_wptr  = vecs[i].wptr;
      rdata_mem = vecs[i].dmem;
      step();
      chk($sformatf("v%0d_empty",  i), 32'(rempty),     32'(vecs[i].e_empty));
      chk($sformatf("v%0d_aempty", i), 32'(raempty),    32'(vecs[i].e_aempty));
      chk($sformatf("v%0d_level",  i), 32'(rlevel),     32'(vecs[i].e_level));
      chk($sformatf("v%0d_addr",   i), 32'(r_addr),     32'(vecs[i].e_addr));
      chk($sformatf("v%0d_ptr",    i), 32'(r_ptr),      32'(vecs[i].e_ptr));
      chk($sformatf("v%0d_valid",  i), 32'(rvalid),     32'(vecs[i].e_valid));
      chk($sformatf("v%0d_rdata",  i), 32'(rdata),      32'(vecs[i].e_rdata));
      chk($sformatf("v%0d_uf",     i), 32'(runderflow), 32'(vecs[i].e_uf));
    end

    // Full occupancy, then drain to rbin=15 and read across the wrap.
    do_reset();
    rinc = 1'b0; rq2_wptr = 5'b11000;
    step();
    chk("full_level",  32'(rlevel),  32'd16);
    chk("full_empty",  32'(rempty),  32'd0);
    chk("full_aempty", 32'(raempty), 32'd0);
    rinc = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rdata_mem = 8'(i + 8'h80);
      step();
    end
    rinc = 1'b0;
    step();
    chk("pre_wrap_ptr",   32'(r_ptr),   32'b01000);
    chk("pre_wrap_level", 32'(rlevel),  32'd1);
    chk("pre_wrap_addr",  32'(r_addr),  32'd15);
    chk("pre_wrap_empty", 32'(rempty),  32'd0);
    rinc = 1'b1; rdata_mem = 8'h5A;
    step();
    rinc = 1'b0;
    chk("wrap_ptr",   32'(r_ptr),      32'b11000);
    chk("wrap_addr",  32'(r_addr),     32'd0);
    chk("wrap_empty", 32'(rempty),     32'd1);
    chk("wrap_level", 32'(rlevel),     32'd0);
    chk("wrap_valid", 32'(rvalid),     32'd1);
    chk("wrap_rdata", 32'(rdata),      32'h5A);
    chk("wrap_uf",    32'(runderflow), 32'd0);
    step();
    chk("wrap_valid_drop", 32'(rvalid), 32'd0);
    chk("wrap_empty_hold", 32'(rempty), 32'd1);

    // Reset asserted the cycle after an accepted read takes effect immediately.
    do_reset();
    rq2_wptr = 5'b00010;
    step();
    rinc = 1'b1; rdata_mem = 8'hC3;
    step();
    chk("mid_valid_before", 32'(rvalid), 32'd1);
    rrst_n = 1'b0;
    #1;
    chk("mid_valid", 32'(rvalid), 32'd0);
    chk("mid_empty", 32'(rempty), 32'd1);
    chk("mid_ptr",   32'(r_ptr),  32'd0);
    chk("mid_rdata", 32'(rdata),  32'd0);
    step();
    chk("mid_hold_ptr", 32'(r_ptr), 32'd0);
    // Release: the first edge after deassertion must already be active.
    rinc = 1'b0;
    rrst_n = 1'b1;
    step();
    chk("rel_empty", 32'(rempty), 32'd0);
    chk("rel_level", 32'(rlevel), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rptr_empty_ctrl.md
RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

Interface
REQ-001 SHALL have parameter data_width, default 8, read data word width.
REQ-002 SHALL have parameter add_width, default 4, memory address width; pointers are add_width+1 bits; depth = 2**add_width.
REQ-003 SHALL have parameter aempty_thresh, default 2, almost-empty level threshold.
REQ-004 SHALL have port rclk  input  1  read-domain clock; the block uses one clock only.
REQ-005 SHALL have port rrst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port rinc  input  1  read request.
REQ-007 SHALL have port rq2_wptr  input  add_width+1  write Gray pointer, already two-flop synchronized into rclk.
REQ-008 SHALL have port rdata_mem  input  data_width  memory read data at r_addr, combinational.
REQ-009 SHALL have port r_addr  output  add_width  memory read address = rbin[add_width-1:0].
REQ-010 SHALL have port r_ptr  output  add_width+1  registered read Gray pointer, sent to the write domain.
REQ-011 SHALL have port rempty  output  1  registered empty flag.
REQ-012 SHALL have port raempty  output  1  registered almost-empty flag.
REQ-013 SHALL have port rlevel  output  add_width+1  registered occupancy, 0..depth.
REQ-014 SHALL have port rdata  output  data_width  registered read data.
REQ-015 SHALL have port rvalid  output  1  rdata-valid strobe.
REQ-016 SHALL have port runderflow  output  1  sticky read-while-empty error.

Function
REQ-017 SHALL accept a read when rinc=1 and rempty=0; rbinnext = rbin + accept, modulo 2**(add_width+1).
REQ-018 SHALL compute rgraynext = (rbinnext>>1) ^ rbinnext and register rbin and r_ptr together every rclk.
REQ-019 SHALL compute rempty_val = (rgraynext == rq2_wptr) and register it into rempty.
REQ-020 SHALL convert rq2_wptr to binary (wq2_bin) combinationally.
REQ-021 SHALL register rlevel = (wq2_bin - rbinnext) modulo 2**(add_width+1); the result is never above depth.
REQ-022 SHALL register raempty = (level_next <= aempty_thresh), level_next being the rlevel D-input.
REQ-023 SHALL capture rdata_mem into rdata on an accepted read; rvalid SHALL be 1 in the following cycle only; rdata SHALL hold its value otherwise.
REQ-024 SHALL give read latency = 1 rclk from an accepted rinc to rvalid.
REQ-025 SHALL, for rinc=1 while rempty=1, hold the pointers and set runderflow; runderflow SHALL stay 1 until reset.
REQ-026 SHALL, on pointer wrap from all-ones to zero, flip the MSB and continue without a glitch in empty or level.
REQ-027 SHALL, on a read accepted in the same cycle rq2_wptr advances, compute empty and level from both new values.

Reset
REQ-028 SHALL, while rrst_n=0, drive rbin=0, r_ptr=0, rempty=1, raempty=1, rlevel=0, rdata=0, rvalid=0, runderflow=0.
REQ-029 SHALL, on reset asserted mid-read, discard the read and deassert rvalid at once.
REQ-030 SHALL release on the first rclk edge after rrst_n rises, with no extra cycle.

Structure
REQ-031 SHALL take default widths and the Gray-to-binary function from the shared fifo_pkg package used by the write-side block.
REQ-032 SHALL put Gray-to-binary conversion in the sub-module gray2bin, parameterized by width.

Verification
REQ-033 SHALL test reset: after reset, rempty=1, raempty=1, rlevel=0, r_ptr=0; rinc=1 -> runderflow=1, r_addr stays 0.
REQ-034 SHALL test a three-word read: rq2_wptr=5'b00010 (bin 3) -> rempty=0, rlevel=3, raempty=0; three rinc cycles -> rvalid 1 cycle after each, r_addr 0,1,2, then rempty=1, r_ptr=5'b00010.
REQ-035 SHALL test full occupancy: rq2_wptr=5'b11000 (bin 16) with rbin=0 -> rlevel=16, rempty=0, raempty=0.
REQ-036 SHALL test wrap: rbin=15, rq2_wptr=5'b11000 (bin 16); one read -> rbin=16, r_ptr=5'b11000, r_addr=0, rempty=1.
REQ-037 SHALL test a simultaneous event: rlevel=1; rinc=1 with rq2_wptr advancing by one in the same cycle -> rempty stays 0, rlevel=1.
REQ-038 SHALL test reset mid-read: rrst_n=0 in the cycle after rinc -> rvalid=0, rempty=1 at once.
